// File: rtl/bitpack_z.sv
// ============================================================================
// Module   : bitpack_z
// Function : Packs the z vector into the BitPack(z, gamma1-1, gamma1) stream,
//            emitted as DATA_OUT_BITS-wide words over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitpack_z #(
  parameter int L              = 7,
  parameter int N              = 256,
  parameter int GAMMA1         = 19,
  parameter int COEFF_WIDTH    = GAMMA1 + 1,
  parameter int Q              = 8380417,
  parameter int COEFF_IN_WIDTH = 24,
  parameter int DATA_OUT_BITS  = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             range_err,
  output logic                             rd_en_vector_z,
  output logic [$clog2(N*L)-1:0]           addr_vector_z,
  input  logic [COEFF_IN_WIDTH-1:0]        dout_vector_z,
  output logic [DATA_OUT_BITS-1:0]         out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic [$clog2(DATA_OUT_BITS):0]   out_last_len
);

  localparam int NUM_COEFFS  = L * N;
  localparam int TOTAL_BITS  = NUM_COEFFS * COEFF_WIDTH;
  localparam int TOTAL_WORDS = (TOTAL_BITS + DATA_OUT_BITS - 1) / DATA_OUT_BITS;
  localparam int AW          = $clog2(NUM_COEFFS);
  localparam int BW          = DATA_OUT_BITS + COEFF_WIDTH;
  localparam int FW          = $clog2(BW + 1);
  localparam int LLW         = $clog2(DATA_OUT_BITS) + 1;
  localparam int SW          = COEFF_IN_WIDTH + 3;

  localparam logic [AW:0]      NUM_C      = (AW+1)'(NUM_COEFFS);
  localparam logic [FW-1:0]    FILL_WORD  = FW'(DATA_OUT_BITS);
  localparam logic [FW-1:0]    FILL_COEFF = FW'(COEFF_WIDTH);
  localparam logic [LLW-1:0]   LAST_LEN_C = LLW'(TOTAL_BITS - (TOTAL_WORDS - 1) * DATA_OUT_BITS);
  localparam logic [COEFF_IN_WIDTH-1:0] HALF_Q = COEFF_IN_WIDTH'((Q - 1) / 2);
  localparam logic signed [SW-1:0] G1_S   = SW'(2 ** GAMMA1);
  localparam logic signed [SW-1:0] Q_S    = SW'(Q);
  localparam logic signed [SW-1:0] ZERO_S = '0;
  localparam logic signed [SW-1:0] MAXP_S = SW'(2 * (2 ** GAMMA1) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [BW-1:0]               buf_q, buf_d;
  logic [FW-1:0]               fill_q, fill_d;
  logic [AW:0]                 issue_q, issue_d;
  logic [AW:0]                 cons_q, cons_d;
  logic                        pend_q;
  logic [COEFF_IN_WIDTH-1:0]   skid_q, skid_d;
  logic                        skid_vld_q, skid_vld_d;
  logic [DATA_OUT_BITS-1:0]    out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_last_q, out_last_d;
  logic                        done_q, done_d;
  logic                        range_err_q, range_err_d;
  logic                        rd_en;

  logic                        w_src_vld;
  logic [COEFF_IN_WIDTH-1:0]   w_src;
  logic signed [SW-1:0]        w_z;
  logic signed [SW-1:0]        w_packed;
  logic                        w_in_range;
  logic [BW-1:0]               w_ins;
  logic [BW-1:0]               w_buf_next;
  logic [FW-1:0]               w_fill_next;
  logic [AW:0]                 w_cons_next;

  // A read captured in the skid register always takes priority over the BRAM port.
  assign w_src_vld = skid_vld_q | pend_q;
  assign w_src     = skid_vld_q ? skid_q : dout_vector_z;

  always_comb begin
    w_z = SW'(w_src);
    if (w_src <= HALF_Q) w_packed = G1_S - w_z;
    else                 w_packed = G1_S + Q_S - w_z;
    w_in_range = (w_packed >= ZERO_S) && (w_packed <= MAXP_S);
  end

  assign w_ins       = BW'(w_packed[COEFF_WIDTH-1:0]) << fill_q;
  assign w_buf_next  = buf_q | w_ins;
  assign w_fill_next = fill_q + FILL_COEFF;
  assign w_cons_next = cons_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    fill_d      = fill_q;
    issue_d     = issue_q;
    cons_d      = cons_q;
    skid_d      = skid_q;
    skid_vld_d  = skid_vld_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    range_err_d = range_err_q;
    rd_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FETCH;
          rd_en       = 1'b1;
          issue_d     = (AW+1)'(1);
          cons_d      = '0;
          buf_d       = '0;
          fill_d      = '0;
          skid_vld_d  = 1'b0;
          range_err_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      FETCH: begin
        if (w_src_vld) begin
          skid_vld_d = 1'b0;
          cons_d     = w_cons_next;
          if (!w_in_range) range_err_d = 1'b1;
          if (issue_q < NUM_C) begin
            rd_en   = 1'b1;
            issue_d = issue_q + 1'b1;
          end
          if (w_fill_next >= FILL_WORD) begin
            out_data_d  = w_buf_next[DATA_OUT_BITS-1:0];
            buf_d       = w_buf_next >> DATA_OUT_BITS;
            fill_d      = w_fill_next - FILL_WORD;
            out_valid_d = 1'b1;
            out_last_d  = (w_cons_next == NUM_C) && (w_fill_next == FILL_WORD);
            state_d     = EMIT;
          end else if (w_cons_next == NUM_C) begin
            out_data_d  = w_buf_next[DATA_OUT_BITS-1:0];
            buf_d       = '0;
            fill_d      = '0;
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            state_d     = FLUSH;
          end else begin
            buf_d  = w_buf_next;
            fill_d = w_fill_next;
          end
        end
      end
      EMIT: begin
        if (pend_q) begin
          skid_d     = dout_vector_z;
          skid_vld_d = 1'b1;
        end
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (cons_q < NUM_C) begin
            state_d = FETCH;
          end else if (fill_q != '0) begin
            out_data_d  = buf_q[DATA_OUT_BITS-1:0];
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            buf_d       = '0;
            fill_d      = '0;
            state_d     = FLUSH;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      fill_q      <= '0;
      issue_q     <= '0;
      cons_q      <= '0;
      pend_q      <= 1'b0;
      skid_q      <= '0;
      skid_vld_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      issue_q     <= issue_d;
      cons_q      <= cons_d;
      pend_q      <= rd_en;
      skid_q      <= skid_d;
      skid_vld_q  <= skid_vld_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      range_err_q <= range_err_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign range_err      = range_err_q;
  assign rd_en_vector_z = rd_en;
  assign addr_vector_z  = (state_q == IDLE) ? '0 : issue_q[AW-1:0];
  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign out_last       = out_last_q;
  assign out_last_len   = LAST_LEN_C;

endmodule

`default_nettype wire

// File: tb/tb_bitpack_z.sv
// ============================================================================
// Module   : tb_bitpack_z
// Function : Directed self-checking bench for bitpack_z against a BitPack model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bitpack_z;

  localparam int NC    = 1792;
  localparam int WORDS = 560;
  localparam int TBITS = NC * 20;
  localparam int G1    = 524288;
  localparam int QM    = 8380417;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, range_err, rd_en_vector_z;
  logic [10:0] addr_vector_z;
  logic [23:0] dout_vector_z = '0;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic [6:0]  out_last_len;

  bitpack_z dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .range_err      (range_err),
    .rd_en_vector_z (rd_en_vector_z),
    .addr_vector_z  (addr_vector_z),
    .dout_vector_z  (dout_vector_z),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .out_last_len   (out_last_len)
  );

  always #5 clk = ~clk;

  logic [23:0] mem [0:NC-1];
  always @(posedge clk) if (rd_en_vector_z) dout_vector_z <= mem[addr_vector_z];

  int          n_cmp = 0;
  int          n_err = 0;
  int          rdy_mode = 0;
  int          done_cnt = 0;
  logic [63:0] rx_q[$];
  logic        rx_last[$];
  logic [TBITS-1:0] exp_stream;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pack_model(input int z);
    if (z <= (QM - 1) / 2) return G1 - z;
    else                   return G1 + QM - z;
  endfunction

  // Consumer side: pick out_ready, record handshakes, check stall stability.
  initial begin
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("stall_data", out_data, prev_data);
          check_eq("stall_valid", {63'd0, out_valid}, 64'd1);
        end
        out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          rx_q.push_back(out_data);
          rx_last.push_back(out_last);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (done) done_cnt++;
      end
    end
  end

  task automatic run_pack(input int mode, input bit glitch, output int cycles);
    rx_q.delete();
    rx_last.delete();
    done_cnt = 0;
    rdy_mode = mode;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cycles = 1;
    while (done_cnt == 0 && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      start = glitch && (cycles == 50 || cycles == 1000);
    end
    start = 1'b0;
    check_eq("done_seen", {63'd0, (cycles < 20000)}, 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic verify_stream(input string tag);
    int p;
    exp_stream = '0;
    for (int k = 0; k < NC; k++) begin
      p = pack_model(int'(mem[k]));
      exp_stream[k*20 +: 20] = p[19:0];
    end
    check_eq({tag, "_count"}, 64'(rx_q.size()), 64'(WORDS));
    for (int w = 0; w < WORDS && w < rx_q.size(); w++) begin
      check_eq($sformatf("%s_w%0d", tag, w), rx_q[w], exp_stream[w*64 +: 64]);
      check_eq($sformatf("%s_last%0d", tag, w), {63'd0, rx_last[w]}, {63'd0, (w == WORDS - 1)});
    end
  endtask

  task automatic fill_zero();
    for (int k = 0; k < NC; k++) mem[k] = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"},  {63'd0, busy}, 64'd0);
    check_eq({tag, "_done"},  {63'd0, done}, 64'd0);
    check_eq({tag, "_rerr"},  {63'd0, range_err}, 64'd0);
    check_eq({tag, "_rden"},  {63'd0, rd_en_vector_z}, 64'd0);
    check_eq({tag, "_addr"},  64'(addr_vector_z), 64'd0);
    check_eq({tag, "_data"},  out_data, 64'd0);
    check_eq({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check_eq({tag, "_last"},  {63'd0, out_last}, 64'd0);
  endtask

  initial begin
    int          cyc;
    int          p;
    logic [63:0] w0;

    fill_zero();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    check_eq("last_len", 64'(out_last_len), 64'd64);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // All-zero vector, consumer always ready
    run_pack(0, 1'b0, cyc);
    verify_stream("zero");
    if (rx_q.size() > 0) begin
      w0 = rx_q[0];
      check_eq("zero_word0", w0, 64'h0800008000080000);
    end
    check_eq("zero_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("zero_rerr", {63'd0, range_err}, 64'd0);
    check_eq("zero_thruput", {63'd0, (cyc <= 5 * WORDS)}, 64'd1);

    // Range extremes in the first word
    mem[0] = 24'(G1);
    mem[1] = 24'(QM - 524287);
    run_pack(0, 1'b0, cyc);
    if (rx_q.size() > 0) begin
      w0 = rx_q[0];
      check_eq("ext_f0", 64'(w0[19:0]), 64'h00000);
      check_eq("ext_f1", 64'(w0[39:20]), 64'hFFFFF);
      check_eq("ext_f2", 64'(w0[59:40]), 64'h80000);
    end
    verify_stream("ext");
    check_eq("ext_rerr", {63'd0, range_err}, 64'd0);

    // Random legal values with a randomly stalling consumer
    for (int k = 0; k < NC; k++) begin
      p = int'($urandom_range(0, 2 * G1 - 1));
      mem[k] = (p <= G1) ? 24'(G1 - p) : 24'(QM - (p - G1));
    end
    run_pack(1, 1'b0, cyc);
    verify_stream("rand");
    check_eq("rand_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("rand_rerr", {63'd0, range_err}, 64'd0);

    // Out-of-range coefficient sets the sticky error; next start clears it
    fill_zero();
    mem[100] = 24'(G1 + 1);
    run_pack(0, 1'b0, cyc);
    verify_stream("rerr");
    check_eq("rerr_set", {63'd0, range_err}, 64'd1);
    mem[100] = '0;
    run_pack(0, 1'b0, cyc);
    check_eq("rerr_clear", {63'd0, range_err}, 64'd0);

    // Asynchronous reset in the middle of a run
    rx_q.delete();
    rx_last.delete();
    rdy_mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (rx_q.size() < 200 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("mid_reach200", {63'd0, (cyc < 5000)}, 64'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid");
    repeat (2) @(negedge clk);
    rx_q.delete();
    rx_last.delete();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("mid_quiet", 64'(rx_q.size()), 64'd0);
    check_eq("mid_quiet_busy", {63'd0, busy}, 64'd0);
    run_pack(0, 1'b0, cyc);
    verify_stream("after_rst");

    // Start pulses while busy are ignored
    run_pack(1, 1'b1, cyc);
    verify_stream("glitch");
    check_eq("glitch_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("glitch_idle", {63'd0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bitpack_z.md
Name: bitpack_z

Overview:
Packs the signature response vector z (L polynomials × N coefficients, stored mod q in BRAM) into the FIPS 204 BitPack(z, gamma1-1, gamma1) byte stream, emitted as DATA_OUT_BITS-wide words.
- This is the encoder counterpart of the y-vector unpacker. Each coefficient becomes a COEFF_WIDTH-bit field holding gamma1 - z.
- It sits between the z-vector BRAM and the signature serializer, which consumes words through a valid/ready handshake.

Parameters:
L, 7, number of polynomials in z
N, 256, coefficients per polynomial
GAMMA1, 19, log2 of gamma1 (gamma1 = 2^GAMMA1)
COEFF_WIDTH, GAMMA1+1, packed field width in bits
Q, 8380417, modulus
COEFF_IN_WIDTH, 24, width of a stored coefficient
DATA_OUT_BITS, 64, output word width
TOTAL_WORDS, ceil(L*N*COEFF_WIDTH/DATA_OUT_BITS), words per packing run (560 at defaults)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  pulse; begins a packing run when the block is idle
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the final word is accepted
range_err  out  1  sticky; set when any coefficient is out of range; cleared on start
rd_en_vector_z  out  1  BRAM read enable
addr_vector_z  out  $clog2(N*L)  BRAM address, coefficient index r*N+i
dout_vector_z  in  COEFF_IN_WIDTH  BRAM data; valid 1 cycle after rd_en
out_data  out  DATA_OUT_BITS  packed word
out_valid  out  1  out_data is valid
out_ready  in  1  consumer accepts the word on out_valid && out_ready
out_last  out  1  high with the final word
out_last_len  out  $clog2(DATA_OUT_BITS)+1  number of valid bits in the final word (64 at defaults); constant

Behaviour:
- Reset values (async rst): busy=0, done=0, range_err=0, rd_en_vector_z=0, addr_vector_z=0, out_data=0, out_valid=0, out_last=0. The FSM returns to IDLE and the bit buffer and all counters clear.
- Reset asserted mid-run aborts the run with no further output. The next start begins again from coefficient 0.
- Coefficient conversion (combinational on dout_vector_z):
  - If z <= (Q-1)/2: packed = gamma1 - z.
  - Otherwise: packed = gamma1 + Q - z.
  - Legal range is packed in [0, 2*gamma1-1]. Any other value sets range_err; the low COEFF_WIDTH bits are still packed.
- Bit order is little-endian. Coefficient k occupies stream bits [k*COEFF_WIDTH +: COEFF_WIDTH], and output word w carries stream bits [w*DATA_OUT_BITS +: DATA_OUT_BITS].
- Buffering: a DATA_OUT_BITS+COEFF_WIDTH bit buffer with a fill counter.
  - Each coefficient is ORed in at offset fill.
  - When fill >= DATA_OUT_BITS, the low word is loaded into the output register and the buffer shifts right by DATA_OUT_BITS.
- FSM states: IDLE, FETCH, EMIT, FLUSH.
  - IDLE: start -> FETCH; issue read of address 0 and set busy. start is ignored when not in IDLE.
  - FETCH: one coefficient is consumed per cycle while fill < DATA_OUT_BITS, with reads pipelined so that address k+1 is issued while k returns. When the buffer holds a full word, load out_data, set out_valid and go to EMIT. If all L*N coefficients are consumed and fill > 0, go to FLUSH.
  - EMIT: hold out_data/out_valid/out_last stable while out_ready=0. On handshake, drop out_valid. Go to FETCH if coefficients remain, FLUSH if a partial word remains, otherwise IDLE with a done pulse. Reads are paused in EMIT; a read already in flight is captured in a one-entry skid register and not lost.
  - FLUSH: emit the zero-padded partial word with out_last=1, wait for handshake, then IDLE with a done pulse.
- out_last is asserted exactly on word TOTAL_WORDS-1.
- Throughput with out_ready held high: at least one word per 5 cycles at defaults.
- out_valid never deasserts without a handshake. out_data does not change while out_valid=1.

Test Plan:
- All z=0, out_ready=1 -> 560 words, each pattern-repeating. Word0=0x0800008000080000. out_last only on word 559. One done pulse. range_err=0.
- z[0]=524288 (gamma1) and z[1]=Q-524287 (-gamma1+1), rest 0 -> word0 bits[19:0]=0x00000, bits[39:20]=0xFFFFF, bits[59:40]=0x80000.
- Random legal z with out_ready toggled randomly -> concatenated stream equals the software BitPack model. out_data stays stable while stalled. No word is dropped or duplicated.
- z[100]=524289 (gamma1+1) -> range_err set and held through done. The next start clears it.
- Assert rst at word 200 of a run -> all outputs return to reset values immediately. A following start produces the full correct 560-word stream.
- start pulsed while busy=1 -> ignored; the stream is unchanged and there is exactly one done pulse.
